// File: rtl/conv_pkg.sv
// Shared conv2d index math and the window generator state encoding.
// Imported by the window generator and by the conv2d engine.
package conv_pkg;

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        PREP = 2'd1,
        SEND = 2'd2
    } state_t;

    // Output feature-map extent along one spatial dimension.
    function automatic int out_dim(input int in_dim, input int pad, input int k, input int stride);
        return (in_dim + 32'sd2 * pad - k) / stride + 32'sd1;
    endfunction

    // Flat element index inside a window; matches the conv weight ordering.
    function automatic int win_index(input int in_ch, input int k_h, input int k_w, input int k);
        return in_ch * k * k + k_h * k + k_w;
    endfunction

endpackage

// File: rtl/frame_buffer.sv
// Whole-frame pixel store: one synchronous write port, NRD combinational read ports.
module frame_buffer #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 64,
    parameter int AW    = 4,
    parameter int NRD   = 4
) (
    input  logic               clk,
    input  logic               we,
    input  logic [AW-1:0]      waddr,
    input  logic [WIDTH-1:0]   wdata,
    input  logic [NRD*AW-1:0]  raddr,
    output logic [NRD*WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem_r [DEPTH];

    // Pixel write; contents are don't-care after reset, so no reset branch.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    for (genvar r = 0; r < NRD; r++) begin : g_rd
        assign rdata[r*WIDTH +: WIDTH] = mem_r[raddr[r*AW +: AW]];
    end

endmodule

// File: rtl/conv_window_gen.sv
// Buffers one raster frame, then emits every zero-padded KxKxC receptive-field
// window in conv weight order, one per out_valid/out_ready handshake.
module conv_window_gen
    import conv_pkg::*;
#(
    parameter int IN_CHANNELS  = 2,
    parameter int IN_HEIGHT    = 4,
    parameter int IN_WIDTH     = 4,
    parameter int KERNEL_SIZE  = 2,
    parameter int STRIDE       = 2,
    parameter int PADDING      = 0,
    parameter int DATA_WIDTH   = 32,
    localparam int OUT_HEIGHT  = out_dim(IN_HEIGHT, PADDING, KERNEL_SIZE, STRIDE),
    localparam int OUT_WIDTH   = out_dim(IN_WIDTH, PADDING, KERNEL_SIZE, STRIDE),
    localparam int WIN_ELEMS   = IN_CHANNELS * KERNEL_SIZE * KERNEL_SIZE,
    localparam int RW          = $clog2(OUT_HEIGHT > 1 ? OUT_HEIGHT : 2),
    localparam int CW          = $clog2(OUT_WIDTH > 1 ? OUT_WIDTH : 2)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [IN_CHANNELS*DATA_WIDTH-1:0] in_pixel,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [WIN_ELEMS*DATA_WIDTH-1:0] out_window,
    output logic [RW-1:0]                   out_row,
    output logic [CW-1:0]                   out_col,
    output logic                            out_last,
    output logic                            frame_done
);

    localparam int K    = KERNEL_SIZE;
    localparam int KK   = K * K;
    localparam int NPIX = IN_HEIGHT * IN_WIDTH;
    localparam int AW   = $clog2(NPIX > 1 ? NPIX : 2);
    localparam int PW   = IN_CHANNELS * DATA_WIDTH;

    state_t                        state_r;
    logic [AW-1:0]                 pix_cnt_r;
    logic [RW-1:0]                 oh_r;
    logic [CW-1:0]                 ow_r;
    logic                          we_s;
    logic                          last_s;
    logic [KK*AW-1:0]              raddr_s;
    logic [KK*PW-1:0]              rdata_s;
    logic [WIN_ELEMS*DATA_WIDTH-1:0] win_s;

    assign we_s   = (state_r == LOAD) && in_valid && in_ready;
    assign last_s = (oh_r == RW'(OUT_HEIGHT - 1)) && (ow_r == CW'(OUT_WIDTH - 1));

    frame_buffer #(
        .DEPTH (NPIX),
        .WIDTH (PW),
        .AW    (AW),
        .NRD   (KK)
    ) u_frame_buffer (
        .clk   (clk),
        .we    (we_s),
        .waddr (pix_cnt_r),
        .wdata (in_pixel),
        .raddr (raddr_s),
        .rdata (rdata_s)
    );

    // One read port per kernel tap; taps landing in the padding border read
    // address 0 and are forced to zero on the way into the window.
    for (genvar kh = 0; kh < K; kh++) begin : g_kh
        for (genvar kw = 0; kw < K; kw++) begin : g_kw
            localparam int TAP = kh * K + kw;
            int   ih_s;
            int   iw_s;
            logic ok_s;

            assign ih_s = int'(oh_r) * STRIDE + kh - PADDING;
            assign iw_s = int'(ow_r) * STRIDE + kw - PADDING;
            assign ok_s = (ih_s >= 32'sd0) && (ih_s < IN_HEIGHT) &&
                          (iw_s >= 32'sd0) && (iw_s < IN_WIDTH);
            assign raddr_s[TAP*AW +: AW] = ok_s ? AW'(ih_s * IN_WIDTH + iw_s) : {AW{1'b0}};

            for (genvar c = 0; c < IN_CHANNELS; c++) begin : g_ch
                assign win_s[win_index(c, kh, kw, K)*DATA_WIDTH +: DATA_WIDTH] =
                    ok_s ? rdata_s[TAP*PW + c*DATA_WIDTH +: DATA_WIDTH] : {DATA_WIDTH{1'b0}};
            end
        end
    end

    // Load / prepare / send sequencer with registered handshake and window outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= LOAD;
            pix_cnt_r  <= {AW{1'b0}};
            oh_r       <= {RW{1'b0}};
            ow_r       <= {CW{1'b0}};
            in_ready   <= 1'b1;
            out_valid  <= 1'b0;
            out_window <= {(WIN_ELEMS*DATA_WIDTH){1'b0}};
            out_row    <= {RW{1'b0}};
            out_col    <= {CW{1'b0}};
            out_last   <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state_r)
                LOAD: begin
                    if (we_s) begin
                        if (pix_cnt_r == AW'(NPIX - 1)) begin
                            pix_cnt_r <= {AW{1'b0}};
                            oh_r      <= {RW{1'b0}};
                            ow_r      <= {CW{1'b0}};
                            in_ready  <= 1'b0;
                            state_r   <= PREP;
                        end else begin
                            pix_cnt_r <= pix_cnt_r + 1'b1;
                        end
                    end
                end
                PREP: begin
                    out_window <= win_s;
                    out_row    <= oh_r;
                    out_col    <= ow_r;
                    out_last   <= last_s;
                    out_valid  <= 1'b1;
                    state_r    <= SEND;
                end
                SEND: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (out_last) begin
                            frame_done <= 1'b1;
                            oh_r       <= {RW{1'b0}};
                            ow_r       <= {CW{1'b0}};
                            in_ready   <= 1'b1;
                            state_r    <= LOAD;
                        end else begin
                            if (ow_r == CW'(OUT_WIDTH - 1)) begin
                                ow_r <= {CW{1'b0}};
                                oh_r <= oh_r + 1'b1;
                            end else begin
                                ow_r <= ow_r + 1'b1;
                            end
                            state_r <= PREP;
                        end
                    end
                end
                default: begin
                    state_r   <= LOAD;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_conv_window_gen.sv
// Scoreboard bench: a default-parameter instance runs all scenarios, a
// K=3/S=1/P=1 instance takes the first frame alongside it.
module tb_conv_window_gen;

    localparam int DW   = 32;
    localparam int WMAX = 18 * DW;

    typedef struct {
        logic [WMAX-1:0] win;
        int              row;
        int              col;
        logic            last;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid;
    logic            p_en;
    logic            out_ready;
    logic [2*DW-1:0] in_pixel;

    logic            in_ready, out_valid, out_last, frame_done;
    logic [8*DW-1:0] out_window;
    logic [0:0]      out_row, out_col;

    logic            in_ready_p, out_valid_p, out_last_p, frame_done_p;
    logic [18*DW-1:0] out_window_p;
    logic [1:0]      out_row_p, out_col_p;

    exp_t q_a[$];
    exp_t q_p[$];
    exp_t e_a, e_p;

    int n_cmp = 0;
    int n_err = 0;
    int fd_cnt = 0, fd_cnt_p = 0, win_cnt = 0, win_cnt_p = 0;

    always #5 clk = ~clk;

    conv_window_gen dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_pixel(in_pixel),
        .out_valid(out_valid), .out_ready(out_ready), .out_window(out_window),
        .out_row(out_row), .out_col(out_col), .out_last(out_last), .frame_done(frame_done)
    );

    conv_window_gen #(.KERNEL_SIZE(3), .STRIDE(1), .PADDING(1)) dut_p (
        .clk(clk), .rst(rst), .in_valid(in_valid & p_en), .in_ready(in_ready_p), .in_pixel(in_pixel),
        .out_valid(out_valid_p), .out_ready(out_ready), .out_window(out_window_p),
        .out_row(out_row_p), .out_col(out_col_p), .out_last(out_last_p), .frame_done(frame_done_p)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk_win(input string nm, input logic [WMAX-1:0] act, input logic [WMAX-1:0] exp, input int n);
        int bad = -1;
        for (int i = 0; i < n; i++) begin
            if (bad < 0 && act[i*DW +: DW] !== exp[i*DW +: DW]) bad = i;
        end
        n_cmp++;
        if (bad >= 0) begin
            n_err++;
            $display("FAIL %s: element %0d got %0d expected %0d at %0t",
                     nm, bad, act[bad*DW +: DW], exp[bad*DW +: DW], $time);
        end
    endtask

    // Reference window from the pixel formula c*16+h*4+w+1+off, zeros outside the frame.
    function automatic logic [WMAX-1:0] model_win(input int k, input int s, input int p,
                                                  input int oh, input int ow, input int off);
        logic [WMAX-1:0] w;
        int ih, iw;
        w = {WMAX{1'b0}};
        for (int c = 0; c < 2; c++)
            for (int kh = 0; kh < k; kh++)
                for (int kw = 0; kw < k; kw++) begin
                    ih = oh * s + kh - p;
                    iw = ow * s + kw - p;
                    if (ih >= 0 && ih < 4 && iw >= 0 && iw < 4)
                        w[(c*k*k + kh*k + kw)*DW +: DW] = 32'(c*16 + ih*4 + iw + 1 + off);
                end
        return w;
    endfunction

    task automatic push_lit(input int v[8], input int row, input int col, input logic last);
        exp_t e;
        e.win = {WMAX{1'b0}};
        for (int i = 0; i < 8; i++) e.win[i*DW +: DW] = 32'(v[i]);
        e.row = row; e.col = col; e.last = last;
        q_a.push_back(e);
    endtask

    task automatic push_model_a(input int off, input int count);
        exp_t e;
        for (int i = 0; i < count; i++) begin
            e.win = model_win(2, 2, 0, i / 2, i % 2, off);
            e.row = i / 2; e.col = i % 2; e.last = (i == 3);
            q_a.push_back(e);
        end
    endtask

    task automatic send_pix(input logic [2*DW-1:0] v, input bit gaps);
        bit got = 1'b0;
        if (gaps && $urandom_range(0, 1) == 1) begin
            in_valid = 1'b0;
            @(posedge clk); #1;
        end
        in_pixel = v;
        in_valid = 1'b1;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (in_ready && (!p_en || in_ready_p)) begin
                got = 1'b1;
                break;
            end
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        if (!got) begin
            n_cmp++; n_err++;
            $display("FAIL pixel_accept_timeout: in_ready never rose at %0t", $time);
        end
    endtask

    task automatic load_frame(input int off, input bit gaps);
        logic [2*DW-1:0] v;
        for (int h = 0; h < 4; h++)
            for (int w = 0; w < 4; w++) begin
                for (int c = 0; c < 2; c++) v[c*DW +: DW] = 32'(c*16 + h*4 + w + 1 + off);
                send_pix(v, gaps);
            end
    endtask

    task automatic wait_done(input int target_a, input int target_p);
        bit got = 1'b0;
        for (int t = 0; t < 400; t++) begin
            @(negedge clk);
            if (fd_cnt >= target_a && fd_cnt_p >= target_p) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            n_cmp++; n_err++;
            $display("FAIL frame_done_timeout: got %0d/%0d expected %0d/%0d", fd_cnt, fd_cnt_p, target_a, target_p);
        end
    endtask

    task automatic wait_win(input int row, input int col);
        bit got = 1'b0;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (out_valid && out_row == 1'(row) && out_col == 1'(col)) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            n_cmp++; n_err++;
            $display("FAIL window_timeout: window (%0d,%0d) never presented", row, col);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_in_ready"},   64'(in_ready),   64'd1);
        chk({tag, "_out_valid"},  64'(out_valid),  64'd0);
        chk_win({tag, "_out_window"}, {320'd0, out_window}, {WMAX{1'b0}}, 8);
        chk({tag, "_out_row"},    64'(out_row),    64'd0);
        chk({tag, "_out_col"},    64'(out_col),    64'd0);
        chk({tag, "_out_last"},   64'(out_last),   64'd0);
        chk({tag, "_frame_done"}, 64'(frame_done), 64'd0);
    endtask

    // Monitor for the default instance: pop and compare on every handshake.
    always @(negedge clk) begin
        if (!rst) begin
            if (frame_done) fd_cnt++;
            if (out_valid && out_ready) begin
                win_cnt++;
                if (q_a.size() == 0) begin
                    n_cmp++; n_err++;
                    $display("FAIL extra_window_a: got (%0d,%0d) expected none", out_row, out_col);
                end else begin
                    e_a = q_a.pop_front();
                    chk_win("window_a", {320'd0, out_window}, e_a.win, 8);
                    chk("row_a",  64'(out_row),  64'(e_a.row));
                    chk("col_a",  64'(out_col),  64'(e_a.col));
                    chk("last_a", 64'(out_last), 64'(e_a.last));
                end
            end
        end
    end

    // Monitor for the padded K=3 instance.
    always @(negedge clk) begin
        if (!rst) begin
            if (frame_done_p) fd_cnt_p++;
            if (out_valid_p && out_ready) begin
                win_cnt_p++;
                if (q_p.size() == 0) begin
                    n_cmp++; n_err++;
                    $display("FAIL extra_window_p: got (%0d,%0d) expected none", out_row_p, out_col_p);
                end else begin
                    e_p = q_p.pop_front();
                    chk_win("window_p", out_window_p, e_p.win, 18);
                    chk("row_p",  64'(out_row_p),  64'(e_p.row));
                    chk("col_p",  64'(out_col_p),  64'(e_p.col));
                    chk("last_p", 64'(out_last_p), 64'(e_p.last));
                end
            end
        end
    end

    initial begin
        logic [8*DW-1:0] cap_w;
        logic [0:0]      cap_r, cap_c;
        exp_t            e;

        rst = 1'b0; in_valid = 1'b0; p_en = 1'b0; out_ready = 1'b1; in_pixel = '0;
        #2 rst = 1'b1;
        #2 chk_reset("reset");
        @(posedge clk); #1 rst = 1'b0;
        @(posedge clk); #1;

        // Scenario 1 + padded scenario 2 on the same frame.
        push_lit('{1, 2, 5, 6, 17, 18, 21, 22},    0, 0, 1'b0);
        push_lit('{3, 4, 7, 8, 19, 20, 23, 24},    0, 1, 1'b0);
        push_lit('{9, 10, 13, 14, 25, 26, 29, 30}, 1, 0, 1'b0);
        push_lit('{11, 12, 15, 16, 27, 28, 31, 32}, 1, 1, 1'b1);
        for (int i = 0; i < 16; i++) begin
            e.win = model_win(3, 1, 1, i / 4, i % 4, 0);
            e.row = i / 4; e.col = i % 4; e.last = (i == 15);
            q_p.push_back(e);
        end
        p_en = 1'b1;
        load_frame(0, 1'b0);
        p_en = 1'b0;
        wait_done(1, 1);
        @(negedge clk);
        chk("in_ready_after_frame", 64'(in_ready), 64'd1);
        @(posedge clk); #1;

        // Scenario 3: back-pressure while window (0,1) is presented.
        out_ready = 1'b0;
        push_model_a(0, 4);
        load_frame(0, 1'b0);
        wait_win(0, 0);
        @(posedge clk); #1 out_ready = 1'b1;
        @(posedge clk); #1 out_ready = 1'b0;
        wait_win(0, 1);
        cap_w = out_window; cap_r = out_row; cap_c = out_col;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_valid", 64'(out_valid), 64'd1);
            chk_win("stall_window", {320'd0, out_window}, {320'd0, cap_w}, 8);
            chk("stall_row", 64'(out_row), 64'(cap_r));
            chk("stall_col", 64'(out_col), 64'(cap_c));
        end
        @(posedge clk); #1 out_ready = 1'b1;
        wait_done(2, 1);
        @(posedge clk); #1;

        // Scenario 4: gapped input, then pixels offered while windows are pending.
        out_ready = 1'b0;
        push_model_a(0, 4);
        load_frame(0, 1'b1);
        in_pixel = {32'd999, 32'd999};
        in_valid = 1'b1;
        wait_win(0, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("in_ready_during_send", 64'(in_ready), 64'd0);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        wait_done(3, 1);
        @(posedge clk); #1;

        // Scenario 5: reset while window (1,0) is presented.
        push_model_a(0, 3);
        load_frame(0, 1'b0);
        wait_win(1, 0);
        #1 rst = 1'b1;
        #1 chk_reset("midframe_reset");
        @(posedge clk); #1 rst = 1'b0;
        @(posedge clk); #1;
        push_model_a(0, 4);
        load_frame(0, 1'b0);
        wait_done(4, 1);
        @(posedge clk); #1;

        // Scenario 6: two frames back-to-back, second one offset by 100.
        push_model_a(0, 4);
        push_lit('{101, 102, 105, 106, 117, 118, 121, 122}, 0, 0, 1'b0);
        for (int i = 1; i < 4; i++) begin
            e.win = model_win(2, 2, 0, i / 2, i % 2, 100);
            e.row = i / 2; e.col = i % 2; e.last = (i == 3);
            q_a.push_back(e);
        end
        load_frame(0, 1'b0);
        load_frame(100, 1'b0);
        wait_done(6, 1);
        repeat (3) @(negedge clk);

        chk("frame_done_count_a", 64'(fd_cnt),    64'd6);
        chk("frame_done_count_p", 64'(fd_cnt_p),  64'd1);
        chk("window_count_a",     64'(win_cnt),   64'd27);
        chk("window_count_p",     64'(win_cnt_p), 64'd16);
        chk("pending_a",          64'(q_a.size()), 64'd0);
        chk("pending_p",          64'(q_p.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/conv_window_gen.md
Name: conv_window_gen

Overview:
- Feeder stage directly upstream of the batched conv2d engine.
- Accepts one input frame as a raster stream of channel-interleaved pixels (valid/ready) and buffers the whole frame on chip.
- Then emits each KERNEL_SIZE x KERNEL_SIZE x IN_CHANNELS receptive-field window, zero-filled for padding, one per handshake.
- The window layout matches the conv weight ordering, so a sequential MAC stage can consume it window by window.

Parameters:
- IN_CHANNELS, 2, channels per pixel.
- IN_HEIGHT, 4, frame rows.
- IN_WIDTH, 4, frame columns.
- KERNEL_SIZE, 2, square kernel edge K.
- STRIDE, 2, window step in both dimensions.
- PADDING, 0, zero border width on every side.
- DATA_WIDTH, 32, element width (signed, passed through untouched).
- Derived localparams:
  - OUT_HEIGHT = (IN_HEIGHT + 2*PADDING - K)/STRIDE + 1
  - OUT_WIDTH likewise from IN_WIDTH
  - WIN_ELEMS = IN_CHANNELS*K*K
  - RW = $clog2(OUT_HEIGHT>1?OUT_HEIGHT:2)
  - CW = $clog2(OUT_WIDTH>1?OUT_WIDTH:2)

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  input pixel valid.
- in_ready  out  1  block can accept a pixel.
- in_pixel  in  IN_CHANNELS*DATA_WIDTH  channel c at bits [c*DATA_WIDTH +: DATA_WIDTH].
- out_valid  out  1  out_window valid.
- out_ready  in  1  downstream accepts window.
- out_window  out  WIN_ELEMS*DATA_WIDTH  element i at [i*DATA_WIDTH +: DATA_WIDTH], i = in_ch*K*K + k_h*K + k_w.
- out_row  out  RW  output row index of current window.
- out_col  out  CW  output column index of current window.
- out_last  out  1  current window is the final window of the frame.
- frame_done  out  1  one-cycle pulse after the last window handshake.

Behaviour:
- Reset: rst is asynchronous, active-high; clk is the only clock. On reset:
  - state=LOAD, pixel counter=0, row/col counters=0
  - in_ready=1, out_valid=0, out_window=0, out_row=0, out_col=0, out_last=0, frame_done=0
  - frame buffer contents are don't-care.
- States: LOAD, PREP, SEND.
- LOAD:
  - in_ready=1.
  - Each cycle with in_valid&in_ready, store in_pixel at buffer[h*IN_WIDTH+w], raster order (w fastest), and increment the counter.
  - Acceptance of pixel IN_HEIGHT*IN_WIDTH-1 transitions to PREP with oh=ow=0.
  - in_valid while not in LOAD is ignored (in_ready=0); no data is lost upstream.
- PREP (one cycle):
  - Registers out_window for (oh,ow).
  - Each element reads buffer at ih=oh*STRIDE+k_h-PADDING, iw=ow*STRIDE+k_w-PADDING, channel in_ch.
  - Element is 0 when ih or iw is outside [0,IN_HEIGHT) / [0,IN_WIDTH).
  - Also registers out_row=oh, out_col=ow, out_last=(oh==OUT_HEIGHT-1 && ow==OUT_WIDTH-1).
  - Next state SEND.
- SEND:
  - out_valid=1. out_window, out_row, out_col and out_last are held stable until out_valid&out_ready.
  - On handshake: out_valid drops next cycle.
  - If not out_last: advance ow, wrap to 0 and increment oh at OUT_WIDTH-1, then go to PREP.
  - If out_last: pulse frame_done for one cycle, then go to LOAD with counters cleared.
- Latency and throughput:
  - out_valid rises 2 cycles after the final pixel handshake.
  - Steady state is one window per 2 cycles with out_ready held high.
  - Load takes IN_HEIGHT*IN_WIDTH cycles at full input rate.
- Back-pressure: out_ready may stay low indefinitely. Outputs must not change and no window may be skipped or duplicated.
- Frames are processed back-to-back. A batch is BATCH_SIZE consecutive frames; no inter-frame state is kept.
- Reset mid-load or mid-emission aborts the frame immediately and returns to the reset values. The partial frame is discarded.
- No arithmetic is done; values are copied bit-exact. Padding zeros are all-zero words.

Decomposition:
- Shared package `conv_pkg`:
  - OUT_HEIGHT/OUT_WIDTH formula functions
  - window element index function (in_ch,k_h,k_w)
  - state enum LOAD/PREP/SEND
- Conv2d uses the same package for its weight and output index math.
- One natural sub-module, `frame_buffer`: IN_HEIGHT*IN_WIDTH-deep, IN_CHANNELS*DATA_WIDTH-wide storage with one write port and combinational read.
- A K*K-read window mux is built in the parent from multiple read addresses.

Test Plan:
- Default params; stream pixels with value c*16+h*4+w+1, in_valid always high, out_ready high:
  - 4 windows in order (0,0),(0,1),(1,0),(1,1)
  - window(0,0) elements = [1,2,5,6,17,18,21,22]
  - window(1,1) = [11,12,15,16,27,28,31,32]
  - out_last only on (1,1); frame_done pulses once; in_ready returns to 1.
- K=3, S=1, PADDING=1, same frame:
  - 16 windows.
  - window(0,0) ch0 part = [0,0,0,0,1,2,0,5,6].
  - window(3,3) ch0 part = [11,12,0,15,16,0,0,0,0].
- Default params, out_ready low for 5 cycles during window(0,1):
  - out_valid stays 1, out_window/out_row/out_col unchanged.
  - Release yields exactly 4 windows total.
- In_valid toggled 1/0 randomly during load, and in_valid=1 asserted during SEND:
  - windows identical to scenario 1.
  - pixels offered during SEND are not consumed (in_ready=0).
- Assert rst for 1 cycle while in SEND of window(1,0):
  - outputs return to reset values asynchronously.
  - a fresh frame afterwards produces scenario 1 results.
- Two frames back-to-back, second frame values +100:
  - 8 windows; frame_done pulses twice.
  - second frame window(0,0) = [101,102,105,106,117,118,121,122].
